ifid_pipe_reg: RTL

IF/ID pipeline register with stall/flush semantics and a one-entry skid slot. It consumes the stall and flush controls produced for the IF/ID boundary and holds or bubbles the fetched instruction accordingly. Instructions returned by synchronous instruction memory while the stage is stalled are captured, not lost. It also exposes saturating stall/flush event counters for the cycle-level debug prints.

---
 rtl/ifid_pipe_reg_pkg.sv | 21 ++
 rtl/ifid_pipe_reg_if.sv | 31 +++
 rtl/ifid_skid_slot.sv | 53 +++++
 rtl/ifid_pipe_reg.sv | 100 ++++++++++
 4 files changed

// File: rtl/ifid_pipe_reg_pkg.sv
// Shared pipeline-register definitions: widths, bubble encoding and skid state.
// Reused by the ID/EXE, EXE/MEM and MEM/WB registers.
package ifid_pipe_reg_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 16;

   // sll $0,$0,0
   localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic {
      SKID_EMPTY = 1'b0,
      SKID_FULL  = 1'b1
   } skid_state_e;

   // Event counters stick at all-ones rather than wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      return (&cnt) ? cnt : cnt + 1'b1;
   endfunction

endpackage

// File: rtl/ifid_pipe_reg_if.sv
// IF/ID boundary bundle: fetch-side inputs, decode-side outputs and debug counters.
interface ifid_pipe_reg_if;
   import ifid_pipe_reg_pkg::*;

   logic              STALL_IN;
   logic              FLUSH_IN;
   logic [DATA_W-1:0] Instr_IN;
   logic [DATA_W-1:0] PC_IN;
   logic              InstrValid_IN;
   logic [DATA_W-1:0] Instr_OUT;
   logic [DATA_W-1:0] PC_OUT;
   logic              Valid_OUT;
   logic              FetchHold_OUT;
   logic              Overflow_OUT;
   logic [CNT_W-1:0]  StallCount_OUT;
   logic [CNT_W-1:0]  FlushCount_OUT;

   // Driver side (fetch / hazard unit).
   modport master (
      output STALL_IN, FLUSH_IN, Instr_IN, PC_IN, InstrValid_IN,
      input  Instr_OUT, PC_OUT, Valid_OUT, FetchHold_OUT, Overflow_OUT,
             StallCount_OUT, FlushCount_OUT
   );

   // Pipeline register side.
   modport slave (
      input  STALL_IN, FLUSH_IN, Instr_IN, PC_IN, InstrValid_IN,
      output Instr_OUT, PC_OUT, Valid_OUT, FetchHold_OUT, Overflow_OUT,
             StallCount_OUT, FlushCount_OUT
   );
endinterface

// File: rtl/ifid_skid_slot.sv
// One-entry instruction+PC buffer that catches fetch returns while IF/ID is stalled.
//
// state      | meaning
// SKID_EMPTY | no buffered instruction
// SKID_FULL  | one instruction buffered; fetch must hold its PC
module ifid_skid_slot
   import ifid_pipe_reg_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              load_i,
   input  logic              drain_i,
   input  logic              clear_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [DATA_W-1:0] pc_i,
   output logic [DATA_W-1:0] data_o,
   output logic [DATA_W-1:0] pc_o,
   output logic              full_o
);

   skid_state_e       state_q, state_d;
   logic [DATA_W-1:0] data_q, pc_q;

   // Slot state register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= SKID_EMPTY;
      else          state_q <= state_d;
   end

   // Clear (wrong path) wins; a load during a drain keeps the slot full.
   always_comb begin
      state_d = state_q;
      if (clear_i)      state_d = SKID_EMPTY;
      else if (load_i)  state_d = SKID_FULL;
      else if (drain_i) state_d = SKID_EMPTY;
   end

   // Buffered entry; only written on a load that is not being squashed.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         data_q <= '0;
         pc_q   <= '0;
      end else if (load_i && !clear_i) begin
         data_q <= data_i;
         pc_q   <= pc_i;
      end
   end

   assign data_o = data_q;
   assign pc_o   = pc_q;
   assign full_o = (state_q == SKID_FULL);

endmodule

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register with stall/flush, skid capture and saturating event counters.
module ifid_pipe_reg
   import ifid_pipe_reg_pkg::*;
(
   input  logic           CLOCK,
   input  logic           RESET,
   ifid_pipe_reg_if.slave bus
);

   logic [DATA_W-1:0] instr_q, instr_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic              valid_q, valid_d;
   logic              ovf_q, ovf_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic              skid_load, skid_drain, skid_clear, skid_full;
   logic [DATA_W-1:0] skid_data, skid_pc;

   ifid_skid_slot u_skid (
      .clk_i   (CLOCK),
      .rst_n_i (RESET),
      .load_i  (skid_load),
      .drain_i (skid_drain),
      .clear_i (skid_clear),
      .data_i  (bus.Instr_IN),
      .pc_i    (bus.PC_IN),
      .data_o  (skid_data),
      .pc_o    (skid_pc),
      .full_o  (skid_full)
   );

   // Next output-register contents and skid controls, flush > stall > advance.
   always_comb begin
      instr_d    = instr_q;
      pc_d       = pc_q;
      valid_d    = valid_q;
      ovf_d      = ovf_q;
      skid_load  = 1'b0;
      skid_drain = 1'b0;
      skid_clear = 1'b0;
      if (bus.FLUSH_IN) begin
         instr_d    = NOP_INSTR;
         valid_d    = 1'b0;
         skid_clear = 1'b1;
      end else if (bus.STALL_IN) begin
         if (bus.InstrValid_IN) begin
            if (!skid_full) skid_load = 1'b1;
            else            ovf_d     = 1'b1;
         end
      end else if (skid_full) begin
         // Older buffered instruction goes first; a new one refills the slot.
         instr_d    = skid_data;
         pc_d       = skid_pc;
         valid_d    = 1'b1;
         skid_drain = 1'b1;
         skid_load  = bus.InstrValid_IN;
      end else begin
         instr_d = bus.InstrValid_IN ? bus.Instr_IN : NOP_INSTR;
         pc_d    = bus.PC_IN;
         valid_d = bus.InstrValid_IN;
      end
   end

   // Debug event counters; a combined stall+flush counts only as a flush.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (bus.FLUSH_IN)      flush_cnt_d = sat_inc(flush_cnt_q);
      else if (bus.STALL_IN) stall_cnt_d = sat_inc(stall_cnt_q);
   end

   // Output register, sticky overflow flag and counters.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         instr_q     <= NOP_INSTR;
         pc_q        <= '0;
         valid_q     <= 1'b0;
         ovf_q       <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         instr_q     <= instr_d;
         pc_q        <= pc_d;
         valid_q     <= valid_d;
         ovf_q       <= ovf_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.Instr_OUT      = instr_q;
   assign bus.PC_OUT         = pc_q;
   assign bus.Valid_OUT      = valid_q;
   assign bus.FetchHold_OUT  = skid_full;
   assign bus.Overflow_OUT   = ovf_q;
   assign bus.StallCount_OUT = stall_cnt_q;
   assign bus.FlushCount_OUT = flush_cnt_q;

endmodule
